mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between instruction-cache refill (I, read-only)
//  and data-cache fill/writeback (D, read/write).
//  One transaction is in flight at a time; ties are arbitrated round-robin.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_arb_rr.sv | 17 +
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the I/D memory port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 64;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;
endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a tie goes to whichever side was not served last.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_owner_t last_owner,
  output logic       grant_valid,
  output arb_owner_t grant_owner
);
  always_comb begin
    grant_valid = i_req | d_req;
    grant_owner = OWN_I;
    if (i_req && d_req) grant_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
    else if (d_req)     grant_owner = OWN_D;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache refill and D-cache fill/writeback,
// one transaction in flight, with a per-transaction timeout and sticky error.
module mem_port_arbiter #(
  parameter int ADDR_W      = mem_arb_pkg::ADDR_W,
  parameter int LINE_W      = mem_arb_pkg::LINE_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_err
);
  import mem_arb_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYC);

  arb_state_t        state;
  arb_owner_t        owner, last_owner, grant_owner;
  logic              grant_valid;
  logic [TW-1:0]     timer;
  logic              timeout;
  logic [LINE_W-1:0] cap_line;

  mem_arb_rr u_rr (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign timeout  = (timer == TW'(TIMEOUT_CYC - 1));
  // Writes and aborts hand back an all-zero line.
  assign cap_line = (mem_ready && !mem_we) ? mem_rdata : '0;

  assign i_ready = (state == ARB_RESP) && (owner == OWN_I);
  assign d_ready = (state == ARB_RESP) && (owner == OWN_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      timer      <= '0;
      arb_err    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (grant_valid) begin
          owner      <= grant_owner;
          last_owner <= grant_owner;
          timer      <= '0;
          mem_req    <= 1'b1;
          state      <= ARB_BUSY;
          if (grant_owner == OWN_D) begin
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else begin
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
          end
        end
        ARB_BUSY: begin
          // A completion arriving on the timeout cycle takes priority over the abort.
          if (mem_ready || timeout) begin
            mem_req <= 1'b0;
            state   <= ARB_RESP;
            if (!mem_ready) arb_err <= 1'b1;
            if (owner == OWN_I) i_rdata <= cap_line;
            else                d_rdata <= cap_line;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences, and
// randomized I/D agents checked against a line-level memory reference.
module tb_mem_port_arbiter;
  logic        clk, rst_n;
  logic        i_req, i_ready, d_req, d_we, d_ready;
  logic [15:0] i_addr, d_addr, mem_addr;
  logic [63:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_ready, arb_err;

  int n_chk, n_fail;
  int mem_lat;          // >0 fixed latency, 0 never respond, <0 random 1..4
  int i_done, d_done;
  logic [63:0] stub_mem[logic [15:0]];
  logic [63:0] ref_mem[logic [15:0]];

  mem_port_arbiter #(.ADDR_W(16), .LINE_W(64), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .arb_err(arb_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [63:0] dflt(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5a5a, 16'hc0de};
  endfunction

  function automatic logic [63:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory stub: pulses mem_ready after mem_req has been high for the chosen latency.
  initial begin
    int cnt, tgt;
    mem_ready = 0; mem_rdata = '0; cnt = 0; tgt = 1;
    forever begin
      @(posedge clk); #1;
      mem_ready = 0;
      if (!mem_req) cnt = 0;
      else begin
        if (cnt == 0) tgt = (mem_lat < 0) ? int'($urandom_range(1, 4)) : mem_lat;
        cnt++;
        if (tgt != 0 && cnt == tgt) begin
          mem_ready = 1;
          if (mem_we) begin
            stub_mem[mem_addr] = mem_wdata;
            mem_rdata = {$urandom, $urandom};
          end else
            mem_rdata = stub_mem.exists(mem_addr) ? stub_mem[mem_addr] : dflt(mem_addr);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          ireq;
    logic [15:0] iaddr;
    bit          dreq;
    bit          dwe;
    logic [15:0] daddr;
    logic [63:0] wdata;
    int          lat;
    bit          first_d;
  } vec_t;
  vec_t vecs[8];

  task automatic run_vec(input int idx, input vec_t v);
    int i_at, d_at, ip, dp, nreq, exp_i_at, exp_d_at;
    bit snap;
    logic s_we; logic [15:0] s_addr; logic [63:0] s_wd, i_got, d_got, exp_i, exp_d;
    i_at = 0; d_at = 0; ip = 0; dp = 0; nreq = 0; snap = 0;
    s_we = 0; s_addr = 0; s_wd = 0; i_got = 0; d_got = 0;
    exp_i = ref_rd(v.iaddr);
    exp_d = v.dwe ? 64'h0 : ref_rd(v.daddr);
    if (v.ireq && v.dreq) begin
      exp_i_at = v.first_d ? 2 * v.lat + 3 : v.lat + 1;
      exp_d_at = v.first_d ? v.lat + 1 : 2 * v.lat + 3;
    end else begin
      exp_i_at = v.ireq ? v.lat + 1 : 0;
      exp_d_at = v.dreq ? v.lat + 1 : 0;
    end
    @(negedge clk);
    mem_lat = v.lat;
    i_addr = v.iaddr; d_addr = v.daddr; d_we = v.dwe; d_wdata = v.wdata;
    i_req = v.ireq; d_req = v.dreq;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_req && i_at == 0 && d_at == 0) nreq++;
      if (mem_req && !snap) begin
        snap = 1; s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
      end
      if (i_ready) begin ip++; if (i_at == 0) begin i_at = c; i_got = i_rdata; end i_req = 0; end
      if (d_ready) begin dp++; if (d_at == 0) begin d_at = c; d_got = d_rdata; end d_req = 0; end
    end
    if (v.dreq && v.dwe) ref_mem[v.daddr] = v.wdata;
    chk($sformatf("v%0d_i_pulses", idx), 64'(ip), 64'(v.ireq));
    chk($sformatf("v%0d_d_pulses", idx), 64'(dp), 64'(v.dreq));
    chk($sformatf("v%0d_i_lat", idx), 64'(i_at), 64'(exp_i_at));
    chk($sformatf("v%0d_d_lat", idx), 64'(d_at), 64'(exp_d_at));
    chk($sformatf("v%0d_memreq_cyc", idx), 64'(nreq), 64'(v.lat));
    if (v.ireq) chk($sformatf("v%0d_i_rdata", idx), i_got, exp_i);
    if (v.dreq) chk($sformatf("v%0d_d_rdata", idx), d_got, exp_d);
    if (v.dreq && (v.first_d || !v.ireq)) begin
      chk($sformatf("v%0d_mem_we", idx), 64'(s_we), 64'(v.dwe));
      chk($sformatf("v%0d_mem_addr", idx), 64'(s_addr), 64'(v.daddr));
      if (v.dwe) chk($sformatf("v%0d_mem_wdata", idx), s_wd, v.wdata);
    end else begin
      chk($sformatf("v%0d_mem_we", idx), 64'(s_we), 64'h0);
      chk($sformatf("v%0d_mem_addr", idx), 64'(s_addr), 64'(v.iaddr));
    end
    chk($sformatf("v%0d_err", idx), 64'(arb_err), 64'h0);
  endtask

  task automatic i_agent(input int n);
    for (int k = 0; k < n; k++) begin
      logic [15:0] a; int so; bit got;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = 16'($urandom_range(0, 7)) << 3;
      i_addr = a; i_req = 1; so = d_done; got = 0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        if (i_ready) begin
          got = 1; i_req = 0; i_done++;
          chk("rnd_i_data", i_rdata, ref_rd(a));
          chk("rnd_i_fair", 64'(d_done - so <= 1), 64'h1);
          chk("rnd_excl", 64'(d_ready), 64'h0);
        end
      end
      if (!got) begin chk("rnd_i_timeout", 64'h0, 64'h1); i_req = 0; end
    end
  endtask

  task automatic d_agent(input int n);
    for (int k = 0; k < n; k++) begin
      logic [15:0] a; logic [63:0] wd, exp; bit we, got; int so;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = 16'($urandom_range(0, 7)) << 3;
      we = 1'($urandom_range(0, 1)); wd = {$urandom, $urandom};
      d_addr = a; d_we = we; d_wdata = wd; d_req = 1; so = i_done; got = 0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        if (d_ready) begin
          got = 1; d_req = 0; d_done++;
          exp = we ? 64'h0 : ref_rd(a);
          chk("rnd_d_data", d_rdata, exp);
          chk("rnd_d_fair", 64'(i_done - so <= 1), 64'h1);
          if (we) ref_mem[a] = wd;
        end
      end
      if (!got) begin chk("rnd_d_timeout", 64'h0, 64'h1); d_req = 0; end
    end
  endtask

  initial begin
    int n, prev, own, nreq, c;
    bit got, d_rearm;
    logic [63:0] rd;
    n_chk = 0; n_fail = 0; i_done = 0; d_done = 0;
    rst_n = 0; i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    mem_lat = 1;
    vecs[0] = '{1, 16'h0080, 1, 0, 16'h0200, 64'h0, 2, 1};
    vecs[1] = '{1, 16'h0088, 1, 1, 16'h0200, 64'h1111_2222_3333_4444, 3, 1};
    vecs[2] = '{1, 16'h0040, 0, 0, 16'h0000, 64'h0, 3, 0};
    vecs[3] = '{0, 16'h0000, 1, 1, 16'h1230, 64'hDEAD_BEEF_0123_4567, 2, 1};
    vecs[4] = '{1, 16'h1230, 1, 0, 16'h0200, 64'h0, 1, 0};
    vecs[5] = '{0, 16'h0000, 1, 0, 16'h1230, 64'h0, 4, 1};
    vecs[6] = '{1, 16'h0200, 1, 1, 16'h0048, 64'hA5A5_0F0F_1234_9876, 1, 0};
    vecs[7] = '{1, 16'h0048, 1, 0, 16'h0088, 64'h0, 5, 0};

    repeat (3) @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'h0);
    chk("rst_i_ready", 64'(i_ready), 64'h0);
    chk("rst_d_ready", 64'(d_ready), 64'h0);
    chk("rst_arb_err", 64'(arb_err), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_i_rdata", i_rdata, 64'h0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

    // I held continuously, D re-requests the cycle after each of its completions.
    @(negedge clk);
    mem_lat = 2; i_addr = 16'h0010; d_addr = 16'h0018; d_we = 0;
    i_req = 1; d_req = 1; n = 0; prev = -1; own = 0; d_rearm = 0;
    for (c = 0; c < 200 && n < 8; c++) begin
      @(negedge clk);
      if (d_rearm) begin d_req = 1; d_rearm = 0; end
      if (i_ready) own = 0;
      if (d_ready) begin own = 1; d_req = 0; d_rearm = 1; end
      if (i_ready || d_ready) begin
        if (n == 0) chk("alt_first_is_i", 64'(own), 64'h0);
        else        chk("alt_switch", 64'(own != prev), 64'h1);
        prev = own; n++;
      end
    end
    chk("alt_count", 64'(n), 64'd8);
    i_req = 0; d_req = 0;
    repeat (3) @(negedge clk);

    // Memory never answers: abort after 8 BUSY cycles, zero data, sticky error.
    mem_lat = 0; i_addr = 16'h0040; i_req = 1; nreq = 0; got = 0; rd = '1;
    for (c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (mem_req) nreq++;
      if (i_ready) begin got = 1; rd = i_rdata; i_req = 0; end
    end
    chk("to_ready", 64'(got), 64'h1);
    chk("to_memreq_cyc", 64'(nreq), 64'd8);
    chk("to_rdata", rd, 64'h0);
    chk("to_err", 64'(arb_err), 64'h1);
    repeat (4) @(negedge clk);
    chk("to_err_sticky", 64'(arb_err), 64'h1);

    // Reset in the middle of a D write.
    mem_lat = 0; d_addr = 16'h0300; d_we = 1; d_wdata = 64'h0bad_0bad_0bad_0bad; d_req = 1;
    repeat (4) @(negedge clk);
    chk("rst6_busy_req", 64'(mem_req), 64'h1);
    chk("rst6_busy_we", 64'(mem_we), 64'h1);
    rst_n = 0; #1;
    chk("rst6_mem_req", 64'(mem_req), 64'h0);
    chk("rst6_d_ready", 64'(d_ready), 64'h0);
    chk("rst6_arb_err", 64'(arb_err), 64'h0);
    d_req = 0;
    got = 0;
    repeat (2) begin @(negedge clk); if (d_ready) got = 1; end
    rst_n = 1;
    mem_lat = 2; i_addr = 16'h0300; i_req = 1; rd = 0; c = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (d_ready) got = 1;
      if (i_ready && c == 0) begin c = k; rd = i_rdata; i_req = 0; end
    end
    chk("rst6_no_d_ready", 64'(got), 64'h0);
    chk("rst6_i_lat", 64'(c), 64'd3);
    chk("rst6_i_rdata", rd, ref_rd(16'h0300));
    chk("rst6_err_clear", 64'(arb_err), 64'h0);

    // mem_ready on the exact timeout cycle completes normally.
    mem_lat = 8; i_addr = 16'h0040; i_req = 1; nreq = 0; got = 0; rd = 0;
    for (c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (mem_req) nreq++;
      if (i_ready) begin got = 1; rd = i_rdata; i_req = 0; end
    end
    chk("edge_memreq_cyc", 64'(nreq), 64'd8);
    chk("edge_rdata", rd, ref_rd(16'h0040));
    chk("edge_err", 64'(arb_err), 64'h0);

    mem_lat = -1;
    fork
      i_agent(25);
      d_agent(25);
    join
    chk("rnd_err", 64'(arb_err), 64'h0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
